// File: rtl/mem_bus_ctrl_pkg.sv
// Shared memory-map constants, region codes and controller state encodings.
// Imported by the controller, its decoder and any block that needs the map.
package mem_bus_ctrl_pkg;

    localparam logic [15:0] ROM_TOP_DEF = 16'h0100;
    localparam logic [15:0] IO_BASE_DEF = 16'hFF00;
    localparam logic [15:0] IO_GPIO_DEF = 16'hFF00;

    typedef enum logic [1:0] {
        REG_ROM = 2'd0,
        REG_RAM = 2'd1,
        REG_IO  = 2'd2
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  wdata;
    } req_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address decoder: 16-bit bus address to ROM/RAM/IO region.
// Also flags the single GPIO latch address.
module mem_addr_decode
    import mem_bus_ctrl_pkg::*;
#(
    parameter logic [15:0] ROM_TOP = ROM_TOP_DEF,
    parameter logic [15:0] IO_BASE = IO_BASE_DEF,
    parameter logic [15:0] IO_GPIO = IO_GPIO_DEF
) (
    input  logic [15:0] addr,
    output region_t     region,
    output logic        is_gpio
);

    always_comb begin
        region = REG_RAM;
        if (addr < ROM_TOP)
            region = REG_ROM;
        else if (addr >= IO_BASE)
            region = REG_IO;
    end

    assign is_gpio = (addr == IO_GPIO);

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-to-memory bus controller: wait-state FSM, read-data register, ROM write
// protection, bus-fault reporting and the GPIO output latch.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 0,
    parameter logic [15:0] ROM_TOP = ROM_TOP_DEF,
    parameter logic [15:0] IO_BASE = IO_BASE_DEF,
    parameter logic [15:0] IO_GPIO = IO_GPIO_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_bus,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        mem_ready,
    output logic        bus_fault,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_rdata,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  gpio_out
);

    localparam logic [3:0] RD_W = 4'(RD_WAIT);
    localparam logic [3:0] WR_W = 4'(WR_WAIT);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    req_t        lat;
    logic        capture;
    logic [15:0] cur_addr;
    logic        cur_rd, cur_wr;
    logic [3:0]  wait_sel;
    region_t     region;
    logic        is_gpio;
    logic        fault;
    logic        enter_ack;
    logic [7:0]  rd_mux;

    // A zero-wait access reaches ACK on the capturing edge, so the memories
    // and decoder must see the live bus during that one IDLE cycle.
    assign capture  = (state == ST_IDLE) && (mem_read || mem_write);
    assign cur_addr = capture ? addr_bus  : lat.addr;
    assign cur_rd   = capture ? mem_read  : lat.rd;
    assign cur_wr   = capture ? mem_write : lat.wr;
    assign wait_sel = mem_read ? RD_W : WR_W;

    mem_addr_decode #(
        .ROM_TOP (ROM_TOP),
        .IO_BASE (IO_BASE),
        .IO_GPIO (IO_GPIO)
    ) u_decode (
        .addr    (cur_addr),
        .region  (region),
        .is_gpio (is_gpio)
    );

    assign fault = cur_wr && (cur_rd || (region == REG_ROM) ||
                              ((region == REG_IO) && !is_gpio));

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (mem_read || mem_write)
                         state_nx = (wait_sel == 4'd0) ? ST_ACK : ST_WAIT;
            ST_WAIT: if (cnt == 4'd1) state_nx = ST_ACK;
            ST_ACK:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign enter_ack = (state_nx == ST_ACK) && (state != ST_ACK);

    always_comb begin
        rd_mux = 8'h00;
        case (region)
            REG_ROM: rd_mux = rom_rdata;
            REG_RAM: rd_mux = ram_rdata;
            REG_IO:  rd_mux = is_gpio ? gpio_out : 8'h00;
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            lat      <= '0;
            rd_data  <= 8'h00;
            gpio_out <= 8'h00;
        end else begin
            state <= state_nx;
            if (capture) begin
                lat <= '{addr: addr_bus, rd: mem_read, wr: mem_write, wdata: wr_data};
                cnt <= wait_sel;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_ack && cur_rd && !cur_wr)
                rd_data <= rd_mux;
            if ((state == ST_ACK) && lat.wr && !fault && (region == REG_IO) && is_gpio)
                gpio_out <= lat.wdata;
        end
    end

    assign mem_ready = (state == ST_ACK);
    assign bus_fault = (state == ST_ACK) && fault;
    assign ram_we    = (state == ST_ACK) && cur_wr && !fault && (region == REG_RAM);
    assign rom_addr  = cur_addr[7:0];
    assign ram_addr  = cur_addr;
    assign ram_wdata = lat.wdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench: two controllers (zero-wait and RD=1/WR=2) against a
// memory-map reference model with randomized accesses.
module tb_mem_bus_ctrl;

    localparam int RDW0 = 0, WDW0 = 0, RDW1 = 1, WDW1 = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_bus [2];
    logic        mem_read [2], mem_write [2];
    logic [7:0]  wr_data [2], rd_data [2];
    logic        mem_ready [2], bus_fault [2], ram_we [2];
    logic [7:0]  rom_addr [2], rom_rdata [2], ram_wdata [2], ram_rdata [2], gpio_out [2];
    logic [15:0] ram_addr [2];

    logic [7:0]  rom [256];
    logic [7:0]  ram0 [65536];
    logic [7:0]  ram1 [65536];
    logic        pl_en [2];
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    logic [7:0]  mram [2][65536];
    logic [7:0]  mgpio [2], mrd [2];
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.RD_WAIT(RDW0), .WR_WAIT(WDW0)) u_dut0 (
        .clk(clk), .reset(reset), .addr_bus(addr_bus[0]), .mem_read(mem_read[0]),
        .mem_write(mem_write[0]), .wr_data(wr_data[0]), .rd_data(rd_data[0]),
        .mem_ready(mem_ready[0]), .bus_fault(bus_fault[0]), .rom_addr(rom_addr[0]),
        .rom_rdata(rom_rdata[0]), .ram_addr(ram_addr[0]), .ram_we(ram_we[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]), .gpio_out(gpio_out[0]));

    mem_bus_ctrl #(.RD_WAIT(RDW1), .WR_WAIT(WDW1)) u_dut1 (
        .clk(clk), .reset(reset), .addr_bus(addr_bus[1]), .mem_read(mem_read[1]),
        .mem_write(mem_write[1]), .wr_data(wr_data[1]), .rd_data(rd_data[1]),
        .mem_ready(mem_ready[1]), .bus_fault(bus_fault[1]), .rom_addr(rom_addr[1]),
        .rom_rdata(rom_rdata[1]), .ram_addr(ram_addr[1]), .ram_we(ram_we[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]), .gpio_out(gpio_out[1]));

    assign rom_rdata[0] = rom[rom_addr[0]];
    assign rom_rdata[1] = rom[rom_addr[1]];
    assign ram_rdata[0] = ram0[ram_addr[0]];
    assign ram_rdata[1] = ram1[ram_addr[1]];

    always @(posedge clk) begin
        if (pl_en[0]) ram0[pl_addr] <= pl_data;
        else if (ram_we[0]) ram0[ram_addr[0]] <= ram_wdata[0];
        if (pl_en[1]) ram1[pl_addr] <= pl_data;
        else if (ram_we[1]) ram1[ram_addr[1]] <= ram_wdata[1];
    end

    function automatic logic [7:0] ram_rd(input int sel, input logic [15:0] a);
        return sel == 0 ? ram0[a] : ram1[a];
    endfunction

    task automatic preload(input int sel, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en[sel] = 1'b1; pl_addr = a; pl_data = d;
        mram[sel][a] = d;
        @(negedge clk);
        pl_en[sel] = 1'b0;
    endtask

    task automatic idle_inputs(input int sel);
        mem_read[sel] = 1'b0; mem_write[sel] = 1'b0;
        addr_bus[sel] = 16'h0000; wr_data[sel] = 8'h00;
    endtask

    // One access on instance sel; expectations come from the memory-map rules.
    task automatic do_access(input int sel, input bit rd, input bit wr,
                             input logic [15:0] a, input logic [7:0] d, input string tag);
        bit is_rom, is_io, gp, flt, exp_we, done;
        int exp_n;
        is_rom = a < 16'h0100;
        is_io  = a >= 16'hFF00;
        gp     = a == 16'hFF00;
        flt    = (rd && wr) || (wr && (is_rom || (is_io && !gp)));
        exp_we = wr && !rd && !is_rom && !is_io;
        exp_n  = rd ? (sel == 0 ? RDW0 : RDW1) : (sel == 0 ? WDW0 : WDW1);
        if (rd && !wr)
            mrd[sel] = is_rom ? rom[a[7:0]] : is_io ? (gp ? mgpio[sel] : 8'h00) : mram[sel][a];
        addr_bus[sel] = a; mem_read[sel] = rd; mem_write[sel] = wr; wr_data[sel] = d;
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (mem_ready[sel] === 1'b1) begin
                done = 1'b1;
                idle_inputs(sel);
                if (!(rd && wr)) begin
                    checks++;
                    if (k != exp_n + 1) begin
                        errors++;
                        $display("FAIL %s latency inst%0d addr=%h: got %0d want %0d", tag, sel, a, k, exp_n + 1);
                    end
                end
                checks++;
                if (bus_fault[sel] !== flt) begin
                    errors++;
                    $display("FAIL %s bus_fault inst%0d addr=%h: got %b want %b", tag, sel, a, bus_fault[sel], flt);
                end
                checks++;
                if (rd_data[sel] !== mrd[sel]) begin
                    errors++;
                    $display("FAIL %s rd_data inst%0d addr=%h: got %h want %h", tag, sel, a, rd_data[sel], mrd[sel]);
                end
                checks++;
                if (ram_we[sel] !== exp_we) begin
                    errors++;
                    $display("FAIL %s ram_we inst%0d addr=%h: got %b want %b", tag, sel, a, ram_we[sel], exp_we);
                end
                if (exp_we) begin
                    checks++;
                    if (ram_addr[sel] !== a || ram_wdata[sel] !== d) begin
                        errors++;
                        $display("FAIL %s ram_bus inst%0d: got %h/%h want %h/%h", tag, sel, ram_addr[sel], ram_wdata[sel], a, d);
                    end
                end
            end else if (ram_we[sel] !== 1'b0 || bus_fault[sel] !== 1'b0) begin
                checks++; errors++;
                $display("FAIL %s strobe_outside_ack inst%0d cycle %0d: we=%b fault=%b want 0", tag, sel, k, ram_we[sel], bus_fault[sel]);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout inst%0d addr=%h: no mem_ready in 20 cycles", tag, sel, a);
            idle_inputs(sel);
        end
        if (!flt && exp_we) mram[sel][a] = d;
        if (!flt && wr && gp) mgpio[sel] = d;
        @(negedge clk);
        checks++;
        if (gpio_out[sel] !== mgpio[sel]) begin
            errors++;
            $display("FAIL %s gpio_out inst%0d: got %h want %h", tag, sel, gpio_out[sel], mgpio[sel]);
        end
        checks++;
        if (mem_ready[sel] !== 1'b0 || ram_we[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s after_ack inst%0d: ready=%b we=%b want 0/0", tag, sel, mem_ready[sel], ram_we[sel]);
        end
        if (wr) begin
            checks++;
            if (ram_rd(sel, a) !== mram[sel][a]) begin
                errors++;
                $display("FAIL %s ram_content inst%0d addr=%h: got %h want %h", tag, sel, a, ram_rd(sel, a), mram[sel][a]);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({rd_data[s], mem_ready[s], bus_fault[s], rom_addr[s], ram_addr[s],
                 ram_we[s], ram_wdata[s], gpio_out[s]} !== '0) begin
                errors++;
                $display("FAIL %s inst%0d: rd=%h rdy=%b flt=%b ra=%h wa=%h we=%b wd=%h gpio=%h want all 0",
                         tag, s, rd_data[s], mem_ready[s], bus_fault[s], rom_addr[s], ram_addr[s],
                         ram_we[s], ram_wdata[s], gpio_out[s]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            idle_inputs(s); pl_en[s] = 1'b0; mgpio[s] = 8'h00; mrd[s] = 8'h00;
        end
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'hA9;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) preload(s, 16'h0100 + 16'(i), 8'($urandom));
            preload(s, 16'h0200, 8'h11);
            preload(s, 16'h0300, 8'h22);
            preload(s, 16'hFEFF, 8'($urandom));
        end
        preload(0, 16'h0100, 8'h3C);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rom_read();
        do_access(1, 1, 0, 16'h0000, 8'h00, "rom_read_wait1");
        do_access(0, 1, 0, 16'h00FF, 8'h00, "rom_top_edge");
    endtask

    task automatic test_ram_zero_wait();
        do_access(0, 1, 0, 16'h0100, 8'h00, "ram_read_wait0");
        do_access(1, 1, 0, 16'hFEFF, 8'h00, "ram_last");
    endtask

    task automatic test_ram_write();
        do_access(1, 0, 1, 16'h0200, 8'h55, "ram_write_wait2");
        do_access(1, 1, 0, 16'h0200, 8'h00, "ram_readback");
        do_access(0, 0, 1, 16'h0100, 8'hC3, "ram_first_write");
        do_access(0, 1, 0, 16'h0100, 8'h00, "ram_first_readback");
    endtask

    task automatic test_rom_protect();
        do_access(1, 0, 1, 16'h0010, 8'hFF, "rom_write_fault");
        do_access(1, 1, 0, 16'h0010, 8'h00, "rom_unchanged");
        do_access(0, 0, 1, 16'h00FF, 8'h12, "rom_top_write_fault");
    endtask

    task automatic test_gpio();
        do_access(1, 0, 1, 16'hFF00, 8'h5A, "gpio_write");
        do_access(1, 1, 0, 16'hFF00, 8'h00, "gpio_read");
        do_access(1, 1, 0, 16'hFF01, 8'h00, "io_other_read");
        do_access(1, 0, 1, 16'hFF01, 8'h77, "io_other_write_fault");
        do_access(1, 1, 0, 16'hFFFF, 8'h00, "io_ffff_read");
        do_access(0, 0, 1, 16'hFF00, 8'hA5, "gpio_write0");
    endtask

    task automatic test_conflict();
        do_access(0, 1, 1, 16'h0105, 8'h99, "rd_wr_conflict0");
        do_access(1, 1, 1, 16'h0106, 8'h98, "rd_wr_conflict1");
    endtask

    // A held request is re-accepted after one IDLE cycle: ready on cycles 1,3,5.
    task automatic test_back_to_back();
        mrd[0] = mram[0][16'h0107];
        addr_bus[0] = 16'h0107; mem_read[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (mem_ready[0] !== 1'((k % 2) == 1)) begin
                errors++;
                $display("FAIL back_to_back ready cycle %0d: got %b want %b", k, mem_ready[0], (k % 2) == 1);
            end
            checks++;
            if (rd_data[0] !== mrd[0]) begin
                errors++;
                $display("FAIL back_to_back rd_data cycle %0d: got %h want %h", k, rd_data[0], mrd[0]);
            end
        end
        idle_inputs(0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        addr_bus[1] = 16'h0300; wr_data[1] = 8'h77; mem_write[1] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle_inputs(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (mem_ready[1] !== 1'b0 || ram_we[1] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid strobe cycle %0d: ready=%b we=%b want 0/0", k, mem_ready[1], ram_we[1]);
            end
        end
        for (int s = 0; s < 2; s++) begin mgpio[s] = 8'h00; mrd[s] = 8'h00; end
        check_all_zero("reset_mid");
        checks++;
        if (ram1[16'h0300] !== mram[1][16'h0300]) begin
            errors++;
            $display("FAIL reset_mid ram_content: got %h want %h", ram1[16'h0300], mram[1][16'h0300]);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] edges [9];
        logic [15:0] a;
        int op;
        edges = '{16'h0000, 16'h00FF, 16'h0100, 16'h0101, 16'h0200,
                  16'hFEFF, 16'hFF00, 16'hFF01, 16'hFFFF};
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 7));
            a  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 8)]
                                             : 16'h0100 + 16'($urandom_range(0, 15));
            do_access(i % 2, op < 4 || op == 7, op >= 4, a, 8'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_ram_zero_wait();
        test_ram_write();
        test_rom_protect();
        test_gpio();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
